// File: rtl/alu_frame_pkg.sv
// Shared definitions for the ALU frame sequencer: FSM state codes, response
// status codes and the default frame-start marker.
package alu_frame_pkg;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_GET_OP    = 4'd1;
   localparam logic [3:0] S_GET_A     = 4'd2;
   localparam logic [3:0] S_GET_B     = 4'd3;
   localparam logic [3:0] S_GET_CHK   = 4'd4;
   localparam logic [3:0] S_CHECK     = 4'd5;
   localparam logic [3:0] S_LATCH     = 4'd6;
   localparam logic [3:0] S_SEND_RES  = 4'd7;
   localparam logic [3:0] S_WAIT_RES  = 4'd8;
   localparam logic [3:0] S_SEND_STAT = 4'd9;
   localparam logic [3:0] S_WAIT_STAT = 4'd10;

   localparam logic [7:0] ST_OK             = 8'h00;
   localparam logic [7:0] ST_CHK_ERR        = 8'h01;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // The byte-collecting states share the inter-byte timeout.
   function automatic logic is_get_state(input logic [3:0] s);
      return s inside {S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK};
   endfunction

endpackage

// File: rtl/alu_frame_sequencer_if.sv
// Bundle of UART, ALU and status signals around the frame sequencer.
// master: the sequencer itself; slave: the UART/ALU environment.
interface alu_frame_sequencer_if #(
   parameter int LEN_DATA = 8,
   parameter int LEN_OP   = 6
);
   logic                rx_done_tick;
   logic [LEN_DATA-1:0] rx_data_in;
   logic [LEN_DATA-1:0] alu_data_in;
   logic                tx_done_tick;
   logic                tx_start;
   logic [LEN_DATA-1:0] data_out;
   logic [LEN_DATA-1:0] A;
   logic [LEN_DATA-1:0] B;
   logic [LEN_OP-1:0]   OPCODE;
   logic                busy;
   logic                frame_err;

   modport master (
      input  rx_done_tick, rx_data_in, alu_data_in, tx_done_tick,
      output tx_start, data_out, A, B, OPCODE, busy, frame_err
   );

   modport slave (
      output rx_done_tick, rx_data_in, alu_data_in, tx_done_tick,
      input  tx_start, data_out, A, B, OPCODE, busy, frame_err
   );
endinterface

// File: rtl/frame_timeout_timer.sv
// Saturating inter-byte timer: clear wins over enable, count holds once it
// reaches TIMEOUT_CYCLES and expired stays high until the next clear.
module frame_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;

   assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked branch and kept out of the sensitivity list.
      if (!reset)                    count <= '0;
      else if (clear)                count <= '0;
      else if (enable && !expired)   count <= count + CNT_W'(1);
   end
endmodule

// File: rtl/alu_frame_sequencer.sv
// Framed command controller: SYNC, OP, A, B[, CHK] in; result and status out.
// Define FRAME_CHECKSUM_EN for the 5-byte frame with XOR checksum.
module alu_frame_sequencer
   import alu_frame_pkg::*;
#(
   parameter int                  LEN_DATA       = 8,
   parameter int                  LEN_OP         = 6,
   parameter logic [LEN_DATA-1:0] SYNC_BYTE      = LEN_DATA'(DEFAULT_SYNC_BYTE),
   parameter int                  TIMEOUT_CYCLES = 1_000_000
) (
   input logic                   clk,
   input logic                   reset,
   alu_frame_sequencer_if.master bus
);
   logic [3:0]          state, next_state;
   logic [LEN_DATA-1:0] a_sh, b_sh, status;
`ifdef FRAME_CHECKSUM_EN
   logic [LEN_DATA-1:0] op_sh, chk_sh;
`else
   logic [LEN_OP-1:0]   op_sh;
`endif
   logic in_get, accept, expired, chk_ok;

   assign in_get   = is_get_state(state);
   assign accept   = bus.rx_done_tick &&
                     (in_get || (state == S_IDLE && bus.rx_data_in == SYNC_BYTE));
   assign bus.busy = (state != S_IDLE);

`ifdef FRAME_CHECKSUM_EN
   assign chk_ok = ((op_sh ^ a_sh ^ b_sh) == chk_sh);
`else
   assign chk_ok = 1'b1;
`endif

   frame_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .enable  (in_get),
      .expired (expired)
   );

   always_comb begin
      // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
      next_state = state;
      case (state)
         S_IDLE:      if (accept) next_state = S_GET_OP;
         S_GET_OP:    if (bus.rx_done_tick) next_state = S_GET_A;
                      else if (expired)     next_state = S_IDLE;
         S_GET_A:     if (bus.rx_done_tick) next_state = S_GET_B;
                      else if (expired)     next_state = S_IDLE;
`ifdef FRAME_CHECKSUM_EN
         S_GET_B:     if (bus.rx_done_tick) next_state = S_GET_CHK;
                      else if (expired)     next_state = S_IDLE;
         S_GET_CHK:   if (bus.rx_done_tick) next_state = S_CHECK;
                      else if (expired)     next_state = S_IDLE;
`else
         S_GET_B:     if (bus.rx_done_tick) next_state = S_CHECK;
                      else if (expired)     next_state = S_IDLE;
`endif
         S_CHECK:     next_state = S_LATCH;
         S_LATCH:     next_state = S_SEND_RES;
         S_SEND_RES:  next_state = S_WAIT_RES;
         S_WAIT_RES:  if (bus.tx_done_tick) next_state = S_SEND_STAT;
         S_SEND_STAT: next_state = S_WAIT_STAT;
         S_WAIT_STAT: if (bus.tx_done_tick) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         op_sh         <= '0;
         a_sh          <= '0;
         b_sh          <= '0;
`ifdef FRAME_CHECKSUM_EN
         chk_sh        <= '0;
`endif
         status        <= '0;
         bus.data_out  <= '0;
         bus.A         <= '0;
         bus.B         <= '0;
         bus.OPCODE    <= '0;
         bus.tx_start  <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state         <= next_state;
         bus.frame_err <= in_get && !bus.rx_done_tick && expired;
         // Result start follows LATCH directly; the status start is issued one
         // cycle after SEND_STAT, giving the freshly loaded status byte setup time.
         bus.tx_start  <= (state == S_LATCH) || (state == S_SEND_STAT);

         if (bus.rx_done_tick) begin
            case (state)
               S_GET_OP:  op_sh  <= bus.rx_data_in[$bits(op_sh)-1:0];
               S_GET_A:   a_sh   <= bus.rx_data_in;
               S_GET_B:   b_sh   <= bus.rx_data_in;
`ifdef FRAME_CHECKSUM_EN
               S_GET_CHK: chk_sh <= bus.rx_data_in;
`endif
               default:   ;
            endcase
         end

         case (state)
            S_CHECK: begin
               status <= chk_ok ? LEN_DATA'(ST_OK) : LEN_DATA'(ST_CHK_ERR);
               if (chk_ok) begin
                  bus.A      <= a_sh;
                  bus.B      <= b_sh;
                  bus.OPCODE <= op_sh[LEN_OP-1:0];
               end
            end
            S_LATCH:    bus.data_out <= (status == LEN_DATA'(ST_OK)) ? bus.alu_data_in : '0;
            S_WAIT_RES: if (bus.tx_done_tick) bus.data_out <= status;
            default:    ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench for alu_frame_sequencer: byte-level frame model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_alu_frame_sequencer;
   localparam int TMO    = 16;
   localparam int TX_LAT = 5;
`ifdef FRAME_CHECKSUM_EN
   localparam int NBYTES = 4;
`else
   localparam int NBYTES = 3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;

   alu_frame_sequencer_if #(.LEN_DATA(8), .LEN_OP(6)) bus ();

   alu_frame_sequencer #(
      .LEN_DATA(8), .LEN_OP(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.alu_data_in = bus.A + bus.B;

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: frame parser over bytes and cycle stamps.
   bit         live = 0, in_frame = 0, responding = 0, pend = 0;
   int         phase = 0, last_acc = 0, now = 0, upd_cyc = -1;
   int         tx1 = -1, tx2 = -1, err_cyc = -1;
   logic [7:0] fb[$];
   logic [7:0] m_a = 0, m_b = 0, p_a = 0, p_b = 0, res = 0, stat = 0;
   logic [5:0] m_op = 0, p_op = 0;

   // Observations.
   logic [7:0] txq[$];
   int         txc[$];
   int         err_cnt = 0;
   int         last_tick = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_frame(input int n);
      logic [7:0] op, a, b;
      bit ok;
      op = fb[0]; a = fb[1]; b = fb[2];
      ok = (NBYTES == 3) || (fb[NBYTES-1] == (op ^ a ^ b));
      if (ok) begin
         pend = 1; p_a = a; p_b = b; p_op = op[5:0]; upd_cyc = n + 2;
      end
      res        = ok ? 8'(a + b) : 8'h00;
      stat       = ok ? 8'h00 : 8'h01;
      tx1        = n + 3;
      tx2        = -1;
      phase      = 1;
      responding = 1;
      in_frame   = 0;
   endtask

   always @(posedge clk) begin
      now = cyc;
      if (!reset) begin
         live = 1; in_frame = 0; responding = 0; pend = 0; phase = 0;
         m_a = 0; m_b = 0; m_op = 0; tx1 = -1; tx2 = -1; err_cyc = -1;
      end else if (responding) begin
         if (bus.tx_done_tick && phase == 1 && now > tx1) begin
            phase = 2; tx2 = now + 2;
         end else if (bus.tx_done_tick && phase == 2 && now >= tx2) begin
            phase = 0; responding = 0;
         end
      end else if (in_frame) begin
         if (bus.rx_done_tick) begin
            fb.push_back(bus.rx_data_in);
            last_acc = now;
            if (fb.size() == NBYTES) finish_frame(now);
         end else if (now == last_acc + TMO + 1) begin
            in_frame = 0; err_cyc = now + 1;
         end
      end else if (bus.rx_done_tick && bus.rx_data_in == 8'hA5) begin
         in_frame = 1; fb.delete(); last_acc = now;
      end
      cyc = cyc + 1;
      if (pend && cyc == upd_cyc) begin
         m_a = p_a; m_b = p_b; m_op = p_op; pend = 0;
      end
   end

   // Compare process and observation log, away from the active edge.
   always @(negedge clk) begin
      if (live) begin
         check("busy",      32'(bus.busy),      32'(in_frame || responding));
         check("tx_start",  32'(bus.tx_start),  32'(cyc == tx1 || cyc == tx2));
         check("frame_err", 32'(bus.frame_err), 32'(cyc == err_cyc));
         check("A",         32'(bus.A),         32'(m_a));
         check("B",         32'(bus.B),         32'(m_b));
         check("OPCODE",    32'(bus.OPCODE),    32'(m_op));
         if (responding && phase == 1 && cyc >= tx1) check("data_out_res",  32'(bus.data_out), 32'(res));
         if (responding && phase == 2 && cyc >= tx2) check("data_out_stat", 32'(bus.data_out), 32'(stat));
         if (bus.tx_start === 1'b1) begin
            txq.push_back(bus.data_out);
            txc.push_back(cyc);
         end
         if (bus.frame_err === 1'b1) err_cnt++;
      end
   end

   // Transmitter: finishes each started byte TX_LAT cycles later.
   initial begin
      bus.tx_done_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            repeat (TX_LAT) @(posedge clk);
            #1 bus.tx_done_tick = 1'b1;
            @(posedge clk);
            #1 bus.tx_done_tick = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic tick(input logic [7:0] d);
      bus.rx_data_in   = d;
      bus.rx_done_tick = 1'b1;
      last_tick        = cyc;
      step();
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, a, b, chk, input int gap0);
      tick(8'hA5); idle(gap0);
      tick(op);    idle(1);
      tick(a);     idle(1);
      tick(b);
`ifdef FRAME_CHECKSUM_EN
      idle(1);
      tick(chk);
`endif
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         step();
         n++;
      end
      total++;
      if (bus.busy) begin
         bad++;
         $display("FAIL wait_idle: busy still %0b after %0d cycles", bus.busy, budget);
      end
   endtask

   task automatic wait_tx(input int count, input int budget);
      int n = 0;
      while (txq.size() < count && n < budget) begin
         step();
         n++;
      end
      check("wait_tx_count", 32'(txq.size() >= count), 32'd1);
   endtask

   task automatic check_resp(input string name, input int base, input logic [7:0] r, s);
      check({name, "_nbytes"}, 32'(txq.size() - base), 32'd2);
      if (txq.size() >= base + 2) begin
         check({name, "_res"},  32'(txq[base]),     32'(r));
         check({name, "_stat"}, 32'(txq[base + 1]), 32'(s));
      end
   endtask

   initial begin
      int base, e0, nt;
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, e0, nt;
      bus.rx_done_tick = 1'b0;
      bus.rx_data_in   = 8'h00;
      reset            = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      check("rst_busy",     32'(bus.busy),      32'd0);
      check("rst_tx_start", 32'(bus.tx_start),  32'd0);
      check("rst_data_out", 32'(bus.data_out),  32'd0);
      check("rst_A",        32'(bus.A),         32'd0);
      check("rst_frame_err",32'(bus.frame_err), 32'd0);
      idle(2);

      // 1: good frame, result 05+03
      base = txq.size();
      send_frame(8'h20, 8'h05, 8'h03, 8'h26, 1);
      wait_idle(60);
      check_resp("t1", base, 8'h08, 8'h00);
      if (txc.size() > base) check("t1_tx_latency", 32'(txc[base] - last_tick), 32'd3);
      check("t1_A",      32'(bus.A),      32'h05);
      check("t1_B",      32'(bus.B),      32'h03);
      check("t1_OPCODE", 32'(bus.OPCODE), 32'h20);
      idle(2);

`ifdef FRAME_CHECKSUM_EN
      // 2: bad checksum keeps operands, reports 00/01
      base = txq.size();
      send_frame(8'h20, 8'h05, 8'h03, 8'h27, 1);
      wait_idle(60);
      check_resp("t2", base, 8'h00, 8'h01);
      check("t2_A",      32'(bus.A),      32'h05);
      check("t2_B",      32'(bus.B),      32'h03);
      check("t2_OPCODE", 32'(bus.OPCODE), 32'h20);
      idle(2);
`endif

      // 6: 0A+01
      base = txq.size();
      send_frame(8'hE0, 8'h0A, 8'h01, 8'hEB, 1);
      wait_idle(60);
      check_resp("t6", base, 8'h0B, 8'h00);
      check("t6_A",      32'(bus.A),      32'h0A);
      check("t6_OPCODE", 32'(bus.OPCODE), 32'h20);
      idle(2);

      // 3: junk byte, partial frame, timeout
      base = txq.size();
      e0   = err_cnt;
      tick(8'h11); idle(1);
      tick(8'hA5); idle(1);
      tick(8'h20);
      idle(TMO + 4);
      check("t3_err_pulses", 32'(err_cnt - e0),     32'd1);
      check("t3_no_tx",      32'(txq.size() - base), 32'd0);
      check("t3_busy",       32'(bus.busy),          32'd0);
      base = txq.size();
      send_frame(8'h20, 8'h05, 8'h03, 8'h26, 1);
      wait_idle(60);
      check_resp("t3_after", base, 8'h08, 8'h00);
      idle(2);

      // byte arriving in the expiry cycle wins
      base = txq.size();
      e0   = err_cnt;
      send_frame(8'h20, 8'h05, 8'h03, 8'h26, TMO);
      wait_idle(60);
      check("edge_err_pulses", 32'(err_cnt - e0), 32'd0);
      check_resp("edge", base, 8'h08, 8'h00);
      idle(2);

      // 4: bytes during WAIT_RES are dropped
      base = txq.size();
      send_frame(8'h20, 8'h05, 8'h03, 8'h26, 1);
      idle(4);
      tick(8'h7F);
      tick(8'hA5);
      wait_idle(60);
      check_resp("t4", base, 8'h08, 8'h00);
      idle(3);
      check("t4_idle", 32'(bus.busy), 32'd0);

      // 5: reset during WAIT_RES; the in-flight tx_done is ignored
      base = txq.size();
      send_frame(8'h20, 8'h05, 8'h03, 8'h26, 1);
      wait_tx(base + 1, 20);
      idle(1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("t5_busy",     32'(bus.busy),     32'd0);
      check("t5_tx_start", 32'(bus.tx_start), 32'd0);
      check("t5_data_out", 32'(bus.data_out), 32'd0);
      check("t5_A",        32'(bus.A),        32'd0);
      check("t5_B",        32'(bus.B),        32'd0);
      check("t5_OPCODE",   32'(bus.OPCODE),   32'd0);
      nt = txq.size();
      idle(12);
      check("t5_no_more_tx", 32'(txq.size() - nt), 32'd0);
      check("t5_still_idle", 32'(bus.busy),        32'd0);

      base = txq.size();
      send_frame(8'h20, 8'hF0, 8'h20, 8'hF0, 1);
      wait_idle(60);
      check_resp("t5_after", base, 8'h10, 8'h00);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_frame_sequencer.md
# alu_frame_sequencer

Framed command controller between the UART receiver/transmitter and the combinational ALU. It hunts for a sync byte and collects opcode, A and B plus an optional XOR checksum. It then commits the operands to the ALU, captures the result and transmits a two-byte response (result, status). An inter-byte timeout stops a broken frame from wedging the link.

## Interface
- `LEN_DATA`, 8, width of UART bytes, operands and result
- `LEN_OP`, 6, ALU opcode width (≤ `LEN_DATA`)
- `SYNC_BYTE`, 8'hA5, frame start marker
- `TIMEOUT_CYCLES`, 1_000_000, max clk cycles between bytes inside a frame
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-low reset
- `rx_done_tick`  in  1  one-cycle pulse, `rx_data_in` valid
- `rx_data_in`  in  `LEN_DATA`  received byte
- `alu_data_in`  in  `LEN_DATA`  ALU result (combinational from A/B/OPCODE)
- `tx_done_tick`  in  1  one-cycle pulse, transmitter finished current byte
- `tx_start`  out  1  one-cycle pulse, transmit `data_out`
- `data_out`  out  `LEN_DATA`  byte to transmit
- `A`, `B`  out  `LEN_DATA`  committed ALU operands
- `OPCODE`  out  `LEN_OP`  committed ALU opcode
- `busy`  out  1  high in any state except IDLE
- `frame_err`  out  1  one-cycle pulse on timeout abort

## Operation
- Frame: SYNC, OP, A, B[, CHK]. CHK = OP ^ A ^ B (full bytes). `OPCODE` takes `OP[LEN_OP-1:0]`; the upper bits of OP are ignored but included in CHK.
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, CHECK, LATCH, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT.
- IDLE: on `rx_done_tick` with byte == `SYNC_BYTE` go to GET_OP. Other bytes are discarded.
- GET_OP, GET_A, GET_B, GET_CHK: each `rx_done_tick` stores the byte in a shadow register and advances. A SYNC value received here is treated as data, not a restart.
- CHECK: if CHK matches, copy the shadow registers to `A`/`B`/`OPCODE` and set status 8'h00. On mismatch, leave the outputs untouched and set status 8'h01.
- LATCH: `data_out` ← `alu_data_in` when status is OK, otherwise 8'h00.
- SEND_RES: pulse `tx_start`, then go to WAIT_RES. WAIT_RES: on `tx_done_tick`, load status into `data_out` and go to SEND_STAT.
- SEND_STAT: pulse `tx_start`, then go to WAIT_STAT. WAIT_STAT: on `tx_done_tick` go to IDLE.
- Timeout: the counter clears on entry to GET_OP and on every accepted byte, and increments every cycle in the GET_* states.
  - On reaching `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_err`, transmit nothing, leave the outputs unchanged.
  - `rx_done_tick` in the same cycle as expiry: the byte wins and the counter clears.
- `rx_done_tick` in CHECK, LATCH and SEND/WAIT states is dropped; there is no buffering.
- `tx_done_tick` outside the WAIT states is ignored.
- Response bytes: result (0x00 on error), then status (0x00 OK, 0x01 checksum error).

## Timing
- Reset (`reset`=0 at a clk edge): state IDLE; `tx_start`, `busy`, `frame_err`, `data_out`, `A`, `B`, `OPCODE`, shadow registers and counter are all 0.
- Reset mid-frame or mid-send aborts immediately. There is no partial response; a transmission already in flight in the transmitter is not recalled.
- Final byte tick at cycle N:
  - CHECK at N+1; new `A`/`B`/`OPCODE` visible from N+2.
  - LATCH at N+2, sampling `alu_data_in`.
  - `tx_start` high at N+3.
- `data_out` is stable from the `tx_start` cycle until the matching `tx_done_tick`.
- Second `tx_start` comes exactly 2 cycles after the first `tx_done_tick`.
- `busy` falls the cycle after the second `tx_done_tick`.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.

## Configuration
- `FRAME_CHECKSUM_EN` defined: 5-byte frame as above; GET_CHK is present and status may be 0x01.
- `FRAME_CHECKSUM_EN` undefined: 4-byte frame, GET_B goes straight to CHECK, the check always passes, status is always 0x00, and no CHK shadow register exists.

## Structure
- Shared package `alu_frame_pkg`: state encodings, status codes `ST_OK`=8'h00 and `ST_CHK_ERR`=8'h01, default `SYNC_BYTE`.
- Sub-module `frame_timeout_timer`: saturating counter with clear/enable inputs and an `expired` output.
- The FSM and datapath registers stay in the top module.

## Test plan
The bench models the ALU as `alu_data_in = A + B` and runs with `FRAME_CHECKSUM_EN` defined unless stated.

1. Frame A5,20,05,03,26 -> `A`=05, `B`=03, `OPCODE`=6'h20; TX bytes 08 then 00; `tx_start` 3 cycles after the last rx tick.
2. Frame A5,20,05,03,27 (bad CHK) -> TX 00 then 01; `A`/`B`/`OPCODE` keep their prior values.
3. Bytes 11 then A5,20 followed by silence of `TIMEOUT_CYCLES`+1 cycles -> 11 ignored, one `frame_err` pulse, no `tx_start`, back in IDLE; the next valid frame is processed normally.
4. Extra byte 7F during WAIT_RES -> dropped; the response is still 08,00 and the FSM returns to IDLE.
5. `reset`=0 during WAIT_RES -> next cycle all outputs are 0 and the state is IDLE; a later `tx_done_tick` is ignored.
6. `FRAME_CHECKSUM_EN` undefined: frame A5,20,0A,01 -> TX 0B then 00.
